// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module : mips_ctrl_pkg
// Brief  : Opcode, state and datapath-select encodings for multicycle_control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    // States that hold a memory request open until mem_ready
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// Module : mem_wait_timer
// Brief  : Counts memory wait cycles; flags expiry at TIMEOUT_CYC (0 = never).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    generate
        if (TIMEOUT_CYC > 0) begin : g_timer
            localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
            logic [CNT_W-1:0] r_count;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_count <= '0;
                end else if (clear) begin
                    r_count <= '0;
                end else if (count_en && !expired) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end

            assign expired = (r_count == CNT_W'(TIMEOUT_CYC));
        end else begin : g_no_timer
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, clear, count_en};
            assign expired  = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module : multicycle_control
// Brief  : Multicycle MIPS control FSM with memory handshake, timeout and fault.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic                instr_retired,
    output logic                fault,
    output logic [3:0]          state_o
);

    state_t r_state;
    state_t w_next;
    logic   w_expired;
    logic   w_clear;
    logic   w_count_en;

    // Leaving a state always restarts the count, so each wait state starts from zero
    assign w_clear    = (w_next != r_state);
    assign w_count_en = is_wait_state(r_state) && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_clear),
        .count_en (w_count_en),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    assign state_o = r_state;

    always_comb begin
        w_next        = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALUOP_W'(ALU_OP_ADD);
        pc_source     = PCSRC_ALU;
        instr_retired = 1'b0;
        fault         = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_expired) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW))
                    w_next = S_MEM_ADDR;
                else if (opcode == OPCODE_W'(OP_RTYPE)) w_next = S_EXEC;
                else if (opcode == OPCODE_W'(OP_BEQ))   w_next = S_BRANCH;
                else if (opcode == OPCODE_W'(OP_J))     w_next = S_JUMP;
                else if (opcode == OPCODE_W'(OP_ADDI))  w_next = S_ADDI_EX;
                else                                    w_next = S_FAULT;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (opcode == OPCODE_W'(OP_LW))      w_next = S_MEM_RD;
                else if (opcode == OPCODE_W'(OP_SW)) w_next = S_MEM_WR;
                else                                 w_next = S_FAULT;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)      w_next = S_MEM_WB;
                else if (w_expired) w_next = S_FAULT;
            end
            S_MEM_WB: begin
                mem_to_reg    = 1'b1;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    w_next        = S_FETCH;
                end else if (w_expired) begin
                    w_next = S_FAULT;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_W'(ALU_OP_FUNCT);
                w_next    = S_R_WB;
            end
            S_R_WB: begin
                reg_dst       = 1'b1;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_W'(ALU_OP_SUB);
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                pc_write      = 1'b1;
                pc_source     = PCSRC_JUMP;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                w_next        = S_FETCH;
            end
            S_FAULT: begin
                fault  = 1'b1;
                w_next = S_FAULT;
            end
            default: begin
                w_next = S_FAULT;
            end
        endcase

        // Reset forces the datapath quiet even though the state already reads FETCH
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = '0;
            pc_source     = 2'b00;
            instr_retired = 1'b0;
            fault         = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module : tb_multicycle_control
// Brief  : Directed vector table plus hand sequences for multicycle_control.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_retired, fault;
    logic [3:0] state_o;

    multicycle_control #(
        .OPCODE_W    (6),
        .ALUOP_W     (2),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_retired (instr_retired),
        .fault         (fault),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    // pw pwc iord mr mw irw m2r rd rw sa | sb | aop | ps | ret flt
    logic [17:0] w_act;
    assign w_act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, instr_retired, fault};

    localparam logic [17:0] E_ZERO       = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_FETCH_RDY  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_FETCH_WAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_DECODE     = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] E_MEM_ADDR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] E_MEM_RD     = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_MEM_WB     = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [17:0] E_WR_WAIT    = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_WR_RDY     = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] E_EXEC       = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] E_R_WB       = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [17:0] E_BRANCH     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [17:0] E_JUMP       = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [17:0] E_ADDI_EX    = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] E_ADDI_WB    = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
    localparam logic [17:0] E_FAULT      = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] AD = 6'b001000, BQ = 6'b000100, JP = 6'b000010, IL = 6'b111111;

    typedef struct packed {
        logic [5:0]  opc;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_retire = 0;

    task automatic add(input logic [5:0] opc, input logic rdy, input logic [3:0] st,
                       input logic [17:0] exp);
        vecs.push_back({opc, rdy, st, exp});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        mem_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Main table: lw, sw with wait states, R, addi, beq, j, then illegal opcode
        add(LW, 1, 0, E_FETCH_RDY); add(LW, 1, 1, E_DECODE); add(LW, 1, 2, E_MEM_ADDR);
        add(LW, 1, 3, E_MEM_RD);    add(LW, 1, 4, E_MEM_WB);
        add(IL, 0, 0, E_FETCH_WAIT); add(SW, 1, 0, E_FETCH_RDY); add(SW, 1, 1, E_DECODE);
        add(SW, 1, 2, E_MEM_ADDR);  add(SW, 0, 5, E_WR_WAIT);   add(SW, 0, 5, E_WR_WAIT);
        add(SW, 0, 5, E_WR_WAIT);   add(SW, 1, 5, E_WR_RDY);
        add(RT, 1, 0, E_FETCH_RDY); add(RT, 1, 1, E_DECODE);    add(RT, 1, 6, E_EXEC);
        add(RT, 1, 7, E_R_WB);
        add(AD, 1, 0, E_FETCH_RDY); add(AD, 1, 1, E_DECODE);    add(AD, 1, 10, E_ADDI_EX);
        add(AD, 1, 11, E_ADDI_WB);
        add(BQ, 1, 0, E_FETCH_RDY); add(BQ, 1, 1, E_DECODE);    add(BQ, 1, 8, E_BRANCH);
        add(JP, 1, 0, E_FETCH_RDY); add(JP, 1, 1, E_DECODE);    add(JP, 1, 9, E_JUMP);
        add(IL, 1, 0, E_FETCH_RDY); add(IL, 1, 1, E_DECODE);    add(IL, 1, 12, E_FAULT);

        #2;
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_outputs", 32'(w_act), 32'(E_ZERO));
        do_reset();

        foreach (vecs[i]) begin
            opcode    = vecs[i].opc;
            mem_ready = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].st));
            check($sformatf("vec%0d_outs", i), 32'(w_act), 32'(vecs[i].exp));
            if (instr_retired) n_retire++;
            step();
        end
        check("retire_count", 32'(n_retire), 32'd6);

        // Fault is sticky regardless of inputs
        for (int i = 0; i < 20; i++) begin
            opcode    = LW;
            mem_ready = i[0];
            @(negedge clk);
            check($sformatf("fault_hold%0d", i), 32'({state_o, fault}), 32'({4'd12, 1'b1}));
            step();
        end
        do_reset();
        @(negedge clk);
        check("fault_cleared", 32'({state_o, fault}), 32'({4'd0, 1'b0}));

        // Timeout in FETCH: 16 wait cycles then FAULT
        do_reset();
        mem_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1 || i == 16)
                check($sformatf("fetch_wait%0d", i), 32'({state_o, mem_read}), 32'({4'd0, 1'b1}));
            step();
        end
        @(negedge clk);
        check("timeout_fault", 32'({state_o, fault}), 32'({4'd12, 1'b1}));

        // Ready arriving in the 16th wait cycle wins over the timeout
        do_reset();
        opcode = RT;
        for (int i = 1; i <= 16; i++) begin
            mem_ready = (i == 16);
            @(negedge clk);
            if (i == 16) check("late_ready_outs", 32'(w_act), 32'(E_FETCH_RDY));
            step();
        end
        @(negedge clk);
        check("late_ready_decode", 32'(state_o), 32'd1);

        // Asynchronous reset in the middle of a stalled read
        do_reset();
        opcode    = LW;
        mem_ready = 1'b1;
        step(); step(); step();
        mem_ready = 1'b0;
        #2;
        check("mem_rd_stall", 32'({state_o, w_act}), 32'({4'd3, E_MEM_RD}));
        rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state_o), 32'd0);
        check("async_rst_outs", 32'(w_act), 32'(E_ZERO));
        step();
        rst = 1'b0;
        #1;
        check("post_rst_fetch", 32'({state_o, w_act}), 32'({4'd0, E_FETCH_WAIT}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
